// File: rtl/multicycle_control_fsm_if.sv
// Control/bus signals between the multicycle control FSM and its datapath
// and memories. master = the control FSM, slave = datapath/memory side.
interface multicycle_control_fsm_if #(
  parameter int INSTR_W  = 16,
  parameter int OPCODE_W = 4,
  parameter int FUNCT_W  = 3
);
  // Inputs to the controller
  logic [INSTR_W-1:0]          imem_rdata;
  logic                        imem_ack;
  logic                        dmem_ack;
  logic                        branch_taken;
  logic                        resume;
  // Memory requests and datapath control
  logic                        imem_req;
  logic                        dmem_req;
  logic                        dmem_we;
  logic                        ir_write;
  logic                        pc_write;
  logic [1:0]                  pc_src;
  logic [OPCODE_W+FUNCT_W-1:0] alu_op;
  logic [1:0]                  alu_src;
  logic                        reg_write;
  logic                        mem_to_reg;
  logic                        rd_is_dest;
  logic                        mtsr_write;
  logic                        mfsr_read;
  logic [FUNCT_W-1:0]          special_sel;
  // Status
  logic [2:0]                  state;
  logic                        halted;
  logic                        timeout_err;
  logic                        trap;

  modport master (
    input  imem_rdata, imem_ack, dmem_ack, branch_taken, resume,
    output imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src,
           alu_op, alu_src, reg_write, mem_to_reg, rd_is_dest,
           mtsr_write, mfsr_read, special_sel, state, halted,
           timeout_err, trap
  );

  modport slave (
    output imem_rdata, imem_ack, dmem_ack, branch_taken, resume,
    input  imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src,
           alu_op, alu_src, reg_write, mem_to_reg, rd_is_dest,
           mtsr_write, mfsr_read, special_sel, state, halted,
           timeout_err, trap
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multicycle processor control FSM: FETCH/DECODE/EXEC/MEM/WB plus HALT and
// TRAP. Memory waits are bounded by a counter; expiry sets a sticky
// timeout_err and parks the machine in HALT.
// Optional feature: define ILLEGAL_TRAP_EN to make opcodes 1100-1110 enter
// TRAP (exit only by reset); otherwise they are NOPs and trap stays 0.
module multicycle_control_fsm #(
  parameter int INSTR_W   = 16,
  parameter int OPCODE_W  = 4,
  parameter int FUNCT_W   = 3,
  parameter int TIMEOUT_W = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  multicycle_control_fsm_if.master   bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_RTYPE_MAX = OPCODE_W'(4'h2);
  localparam logic [OPCODE_W-1:0] OP_JR_GRP    = OPCODE_W'(4'h1);
  localparam logic [OPCODE_W-1:0] OP_IMM_A     = OPCODE_W'(4'h3);
  localparam logic [OPCODE_W-1:0] OP_IMM_B     = OPCODE_W'(4'h4);
  localparam logic [OPCODE_W-1:0] OP_BNEQ      = OPCODE_W'(4'h5);
  localparam logic [OPCODE_W-1:0] OP_BGTZ      = OPCODE_W'(4'h6);
  localparam logic [OPCODE_W-1:0] OP_JUMP      = OPCODE_W'(4'h7);
  localparam logic [OPCODE_W-1:0] OP_LOAD      = OPCODE_W'(4'h8);
  localparam logic [OPCODE_W-1:0] OP_STORE     = OPCODE_W'(4'h9);
  localparam logic [OPCODE_W-1:0] OP_MFSR      = OPCODE_W'(4'hA);
  localparam logic [OPCODE_W-1:0] OP_MTSR      = OPCODE_W'(4'hB);
  localparam logic [OPCODE_W-1:0] OP_NOP_LO    = OPCODE_W'(4'hC);
  localparam logic [OPCODE_W-1:0] OP_NOP_HI    = OPCODE_W'(4'hE);
  localparam logic [OPCODE_W-1:0] OP_HALT      = OPCODE_W'(4'hF);

  localparam logic [1:0] PC_INC    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_REG    = 2'd3;
  localparam logic [1:0] SRC_IMM   = 2'd1;
  localparam logic [1:0] SRC_ZERO  = 2'd2;

  // Count value on whose no-ack cycle the wait reaches 2^TIMEOUT_W-1 cycles
  localparam logic [TIMEOUT_W-1:0] WAIT_LAST = TIMEOUT_W'((1 << TIMEOUT_W) - 2);

  state_t                 r_state;
  logic [INSTR_W-1:0]     r_ir;
  logic [TIMEOUT_W-1:0]   r_wait_cnt;
  logic                   r_timeout_err;

  logic [OPCODE_W-1:0]    w_opcode;
  logic [FUNCT_W-1:0]     w_funct;
  logic                   w_wait_expired;
  logic                   w_is_branch;
  logic                   w_is_jr;
  logic                   w_is_mem;
  logic                   w_is_imm;
  logic                   w_is_nop;
  // Register-specifier fields of IR feed the datapath, not this controller
  logic                   w_ir_unused;

  assign w_opcode       = r_ir[INSTR_W-1 -: OPCODE_W];
  assign w_funct        = r_ir[FUNCT_W-1:0];
  assign w_ir_unused    = ^r_ir;
  assign w_wait_expired = (r_wait_cnt == WAIT_LAST);
  assign w_is_branch    = (w_opcode == OP_BNEQ) || (w_opcode == OP_BGTZ);
  assign w_is_jr        = (w_opcode == OP_JR_GRP) && (w_funct == '1);
  assign w_is_mem       = (w_opcode == OP_LOAD) || (w_opcode == OP_STORE);
  assign w_is_imm       = (w_opcode == OP_IMM_A) || (w_opcode == OP_IMM_B);
  assign w_is_nop       = (w_opcode >= OP_NOP_LO) && (w_opcode <= OP_NOP_HI);

  // State sequencing, IR capture, memory-wait counter and sticky timeout flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_FETCH;
      r_ir          <= '0;
      r_wait_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (bus.imem_ack) begin
            r_ir       <= bus.imem_rdata;
            r_wait_cnt <= '0;
            r_state    <= S_DECODE;
          end else if (w_wait_expired) begin
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b1;
            r_state       <= S_HALT;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        S_DECODE: begin
          if (w_opcode == OP_HALT)      r_state <= S_HALT;
          else if (w_opcode == OP_JUMP) r_state <= S_FETCH;
`ifdef ILLEGAL_TRAP_EN
          else if (w_is_nop)            r_state <= S_TRAP;
`else
          else if (w_is_nop)            r_state <= S_FETCH;
`endif
          else                          r_state <= S_EXEC;
        end
        S_EXEC: begin
          if (w_is_mem)                                         r_state <= S_MEM;
          else if (w_is_branch || w_is_jr || w_opcode == OP_MTSR) r_state <= S_FETCH;
          else                                                  r_state <= S_WB;
        end
        S_MEM: begin
          if (bus.dmem_ack) begin
            r_wait_cnt <= '0;
            r_state    <= (w_opcode == OP_LOAD) ? S_WB : S_FETCH;
          end else if (w_wait_expired) begin
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b1;
            r_state       <= S_HALT;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        S_WB:   r_state <= S_FETCH;
        S_HALT: if (bus.resume) r_state <= S_FETCH;
`ifdef ILLEGAL_TRAP_EN
        S_TRAP: r_state <= S_TRAP;
`endif
        default: r_state <= S_FETCH;
      endcase
    end
  end

  logic                 w_imem_req, w_dmem_req, w_dmem_we, w_ir_write, w_pc_write;
  logic [1:0]           w_pc_src, w_alu_src;
  logic                 w_reg_write, w_mem_to_reg, w_rd_is_dest;
  logic                 w_mtsr_write, w_mfsr_read, w_halted, w_trap;
  logic [FUNCT_W-1:0]   w_special_sel;

  // Control strobes decoded from current state, IR and same-cycle inputs
  always_comb begin
    w_imem_req    = 1'b0;
    w_dmem_req    = 1'b0;
    w_dmem_we     = 1'b0;
    w_ir_write    = 1'b0;
    w_pc_write    = 1'b0;
    w_pc_src      = PC_INC;
    w_alu_src     = 2'd0;
    w_reg_write   = 1'b0;
    w_mem_to_reg  = 1'b0;
    w_rd_is_dest  = 1'b0;
    w_mtsr_write  = 1'b0;
    w_mfsr_read   = 1'b0;
    w_special_sel = '0;
    w_halted      = 1'b0;
    w_trap        = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_imem_req = 1'b1;
        if (bus.imem_ack) begin
          w_ir_write = 1'b1;
          w_pc_write = 1'b1;
        end
      end
      S_DECODE: begin
        if (w_opcode == OP_JUMP) begin
          w_pc_write = 1'b1;
          w_pc_src   = PC_JUMP;
        end
      end
      S_EXEC: begin
        if (w_is_branch) begin
          w_pc_write = bus.branch_taken;
          w_pc_src   = PC_BRANCH;
          if (w_opcode == OP_BGTZ) w_alu_src = SRC_ZERO;
        end else if (w_is_jr) begin
          w_pc_write = 1'b1;
          w_pc_src   = PC_REG;
        end else if (w_is_mem || w_is_imm) begin
          w_alu_src = SRC_IMM;
        end else if (w_opcode == OP_MTSR) begin
          w_mtsr_write  = 1'b1;
          w_special_sel = w_funct;
        end
      end
      S_MEM: begin
        w_dmem_req = 1'b1;
        w_dmem_we  = (w_opcode == OP_STORE);
      end
      S_WB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = (w_opcode == OP_LOAD);
        w_rd_is_dest = !(w_is_imm || w_opcode == OP_LOAD);
        if (w_opcode == OP_MFSR) begin
          w_mfsr_read   = 1'b1;
          w_special_sel = w_funct;
        end
      end
      S_HALT: w_halted = 1'b1;
      S_TRAP: begin
        w_halted = 1'b1;
        w_trap   = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.imem_req    = w_imem_req;
  assign bus.dmem_req    = w_dmem_req;
  assign bus.dmem_we     = w_dmem_we;
  assign bus.ir_write    = w_ir_write;
  assign bus.pc_write    = w_pc_write;
  assign bus.pc_src      = w_pc_src;
  assign bus.alu_op      = (w_opcode <= OP_RTYPE_MAX) ? {w_opcode, w_funct}
                                                      : {w_opcode, {FUNCT_W{1'b0}}};
  assign bus.alu_src     = w_alu_src;
  assign bus.reg_write   = w_reg_write;
  assign bus.mem_to_reg  = w_mem_to_reg;
  assign bus.rd_is_dest  = w_rd_is_dest;
  assign bus.mtsr_write  = w_mtsr_write;
  assign bus.mfsr_read   = w_mfsr_read;
  assign bus.special_sel = w_special_sel;
  assign bus.state       = r_state;
  assign bus.halted      = w_halted;
  assign bus.timeout_err = r_timeout_err;
`ifdef ILLEGAL_TRAP_EN
  assign bus.trap        = w_trap;
`else
  assign bus.trap        = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed self-checking bench for multicycle_control_fsm.
module tb_multicycle_control_fsm;

  localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
                         S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5, S_TRAP = 3'd6;

  // Strobe bit positions within the packed strobe vector
  localparam logic [11:0] B_IMEM = 12'h800, B_DMEM = 12'h400, B_WE   = 12'h200,
                          B_IRW  = 12'h100, B_PCW  = 12'h080, B_RW   = 12'h040,
                          B_M2R  = 12'h020, B_RD   = 12'h010, B_MTSR = 12'h008,
                          B_MFSR = 12'h004, B_HALT = 12'h002, B_TRAP = 12'h001;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  multicycle_control_fsm_if #(.INSTR_W(16), .OPCODE_W(4), .FUNCT_W(3)) bus ();

  multicycle_control_fsm #(.INSTR_W(16), .OPCODE_W(4), .FUNCT_W(3), .TIMEOUT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // obs = {state, pc_src, alu_src, special_sel, timeout_err, strobes}
  logic [11:0] strb;
  logic [22:0] obs;
  logic [22:0] exp_v;
  assign strb = {bus.imem_req, bus.dmem_req, bus.dmem_we, bus.ir_write, bus.pc_write,
                 bus.reg_write, bus.mem_to_reg, bus.rd_is_dest, bus.mtsr_write,
                 bus.mfsr_read, bus.halted, bus.trap};
  assign obs  = {bus.state, bus.pc_src, bus.alu_src, bus.special_sel, bus.timeout_err, strb};

  // Advance one clock; returns 1 time unit after the falling edge
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Present an instruction with ack in the current FETCH cycle
  task automatic do_fetch(input logic [15:0] instr);
    bus.imem_rdata = instr;
    bus.imem_ack   = 1'b1;
    tick();
    bus.imem_ack   = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    exp_v = {S_FETCH, 2'd0, 2'd0, 3'd0, 1'b0, B_IMEM};
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL reset_during: got %h want %h", obs, exp_v); end
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL reset_after: got %h want %h", obs, exp_v); end
    $display("tb: reset sequence checked");
  endtask

  task automatic test_rtype();
    bus.imem_rdata = 16'h0012;
    bus.imem_ack   = 1'b1;
    #1;
    exp_v = {S_FETCH, 2'd0, 2'd0, 3'd0, 1'b0, B_IMEM | B_IRW | B_PCW};
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL rtype_fetch: got %h want %h", obs, exp_v); end
    tick();
    bus.imem_ack = 1'b0;
    #1;
    exp_v = {S_DECODE, 2'd0, 2'd0, 3'd0, 1'b0, 12'h000};
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL rtype_decode: got %h want %h", obs, exp_v); end
    tick();
    exp_v = {S_EXEC, 2'd0, 2'd0, 3'd0, 1'b0, 12'h000};
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL rtype_exec: got %h want %h", obs, exp_v); end
    n_cmp++;
    if (bus.alu_op !== 7'h02) begin n_err++; $display("FAIL rtype_aluop: got %h want 02", bus.alu_op); end
    tick();
    exp_v = {S_WB, 2'd0, 2'd0, 3'd0, 1'b0, B_RW | B_RD};
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL rtype_wb: got %h want %h", obs, exp_v); end
    tick();
    exp_v = {S_FETCH, 2'd0, 2'd0, 3'd0, 1'b0, B_IMEM};
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL rtype_refetch: got %h want %h", obs, exp_v); end
    $display("tb: rtype 0x0012 transaction");
  endtask

  task automatic test_load();
    do_fetch(16'h8123);
    tick();
    exp_v = {S_EXEC, 2'd0, 2'd1, 3'd0, 1'b0, 12'h000};
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL load_exec: got %h want %h", obs, exp_v); end
    n_cmp++;
    if (bus.alu_op !== 7'h40) begin n_err++; $display("FAIL load_aluop: got %h want 40", bus.alu_op); end
    exp_v = {S_MEM, 2'd0, 2'd0, 3'd0, 1'b0, B_DMEM};
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 2) begin bus.dmem_ack = 1'b1; #1; end
      n_cmp++;
      if (obs !== exp_v) begin n_err++; $display("FAIL load_mem_wait%0d: got %h want %h", i, obs, exp_v); end
    end
    tick();
    bus.dmem_ack = 1'b0;
    #1;
    exp_v = {S_WB, 2'd0, 2'd0, 3'd0, 1'b0, B_RW | B_M2R};
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL load_wb: got %h want %h", obs, exp_v); end
    tick();
    $display("tb: load 0x8123 transaction");
  endtask

  task automatic test_store();
    do_fetch(16'h9000);
    tick();
    tick();
    bus.dmem_ack = 1'b1;
    #1;
    exp_v = {S_MEM, 2'd0, 2'd0, 3'd0, 1'b0, B_DMEM | B_WE};
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL store_mem: got %h want %h", obs, exp_v); end
    tick();
    bus.dmem_ack = 1'b0;
    #1;
    exp_v = {S_FETCH, 2'd0, 2'd0, 3'd0, 1'b0, B_IMEM};
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL store_refetch: got %h want %h", obs, exp_v); end
    $display("tb: store 0x9000 transaction");
  endtask

  task automatic test_branch();
    do_fetch(16'h5000);
    tick();
    bus.branch_taken = 1'b1;
    #1;
    exp_v = {S_EXEC, 2'd1, 2'd0, 3'd0, 1'b0, B_PCW};
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL bneq_taken: got %h want %h", obs, exp_v); end
    tick();
    bus.branch_taken = 1'b0;
    #1;
    exp_v = {S_FETCH, 2'd0, 2'd0, 3'd0, 1'b0, B_IMEM};
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL bneq_refetch: got %h want %h", obs, exp_v); end
    do_fetch(16'h5000);
    tick();
    exp_v = {S_EXEC, 2'd1, 2'd0, 3'd0, 1'b0, 12'h000};
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL bneq_not_taken: got %h want %h", obs, exp_v); end
    tick();
    do_fetch(16'h6000);
    tick();
    bus.branch_taken = 1'b1;
    #1;
    exp_v = {S_EXEC, 2'd1, 2'd2, 3'd0, 1'b0, B_PCW};
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL bgtz_taken: got %h want %h", obs, exp_v); end
    tick();
    bus.branch_taken = 1'b0;
    #1;
    $display("tb: branch bneq/bgtz transactions");
  endtask

  task automatic test_jump();
    do_fetch(16'h7000);
    exp_v = {S_DECODE, 2'd2, 2'd0, 3'd0, 1'b0, B_PCW};
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL jump_decode: got %h want %h", obs, exp_v); end
    tick();
    exp_v = {S_FETCH, 2'd0, 2'd0, 3'd0, 1'b0, B_IMEM};
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL jump_refetch: got %h want %h", obs, exp_v); end
    do_fetch(16'h1007);
    tick();
    exp_v = {S_EXEC, 2'd3, 2'd0, 3'd0, 1'b0, B_PCW};
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL jr_exec: got %h want %h", obs, exp_v); end
    n_cmp++;
    if (bus.alu_op !== 7'h0F) begin n_err++; $display("FAIL jr_aluop: got %h want 0f", bus.alu_op); end
    tick();
    $display("tb: jump 0x7000 and jr 0x1007 transactions");
  endtask

  task automatic test_special();
    do_fetch(16'hB005);
    tick();
    exp_v = {S_EXEC, 2'd0, 2'd0, 3'd5, 1'b0, B_MTSR};
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL mtsr_exec: got %h want %h", obs, exp_v); end
    tick();
    do_fetch(16'hA006);
    tick();
    tick();
    exp_v = {S_WB, 2'd0, 2'd0, 3'd6, 1'b0, B_RW | B_MFSR | B_RD};
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL mfsr_wb: got %h want %h", obs, exp_v); end
    tick();
    $display("tb: mtsr 0xB005 and mfsr 0xA006 transactions");
  endtask

  task automatic test_imm();
    do_fetch(16'h3000);
    tick();
    exp_v = {S_EXEC, 2'd0, 2'd1, 3'd0, 1'b0, 12'h000};
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL imm_exec: got %h want %h", obs, exp_v); end
    tick();
    exp_v = {S_WB, 2'd0, 2'd0, 3'd0, 1'b0, B_RW};
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL imm_wb: got %h want %h", obs, exp_v); end
    tick();
    $display("tb: immediate 0x3000 transaction");
  endtask

  task automatic test_illegal();
    do_fetch(16'hC000);
    tick();
`ifdef ILLEGAL_TRAP_EN
    exp_v = {S_TRAP, 2'd0, 2'd0, 3'd0, 1'b0, B_HALT | B_TRAP};
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL trap_enter: got %h want %h", obs, exp_v); end
    bus.resume = 1'b1;
    tick();
    bus.resume = 1'b0;
    #1;
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL trap_resume_ignored: got %h want %h", obs, exp_v); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
`else
    exp_v = {S_FETCH, 2'd0, 2'd0, 3'd0, 1'b0, B_IMEM};
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL nop_refetch: got %h want %h", obs, exp_v); end
`endif
    $display("tb: opcode 0xC000 transaction");
  endtask

  task automatic test_halt();
    do_fetch(16'hF000);
    tick();
    exp_v = {S_HALT, 2'd0, 2'd0, 3'd0, 1'b0, B_HALT};
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL halt_enter: got %h want %h", obs, exp_v); end
    tick();
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL halt_hold: got %h want %h", obs, exp_v); end
    bus.resume = 1'b1;
    tick();
    bus.resume = 1'b0;
    #1;
    exp_v = {S_FETCH, 2'd0, 2'd0, 3'd0, 1'b0, B_IMEM};
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL halt_resume: got %h want %h", obs, exp_v); end
    $display("tb: halt 0xF000 transaction");
  endtask

  // Ack arriving on the 15th wait cycle must win over the timeout
  task automatic test_ack_at_limit();
    for (int i = 0; i < 14; i++) tick();
    exp_v = {S_FETCH, 2'd0, 2'd0, 3'd0, 1'b0, B_IMEM};
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL limit_wait: got %h want %h", obs, exp_v); end
    do_fetch(16'h7000);
    exp_v = {S_DECODE, 2'd2, 2'd0, 3'd0, 1'b0, B_PCW};
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL limit_ack_wins: got %h want %h", obs, exp_v); end
    tick();
    $display("tb: ack at wait limit transaction");
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 14; i++) tick();
    exp_v = {S_FETCH, 2'd0, 2'd0, 3'd0, 1'b0, B_IMEM};
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL timeout_before: got %h want %h", obs, exp_v); end
    tick();
    exp_v = {S_HALT, 2'd0, 2'd0, 3'd0, 1'b1, B_HALT};
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL timeout_halt: got %h want %h", obs, exp_v); end
    bus.resume = 1'b1;
    tick();
    bus.resume = 1'b0;
    #1;
    exp_v = {S_FETCH, 2'd0, 2'd0, 3'd0, 1'b1, B_IMEM};
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL timeout_resume_sticky: got %h want %h", obs, exp_v); end
    $display("tb: imem timeout transaction");
  endtask

  task automatic test_reset_in_mem();
    do_fetch(16'h8000);
    tick();
    tick();
    exp_v = {S_MEM, 2'd0, 2'd0, 3'd0, 1'b1, B_DMEM};
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL rstmem_mem: got %h want %h", obs, exp_v); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    exp_v = {S_FETCH, 2'd0, 2'd0, 3'd0, 1'b0, B_IMEM};
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL rstmem_fetch: got %h want %h", obs, exp_v); end
    tick();
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL rstmem_after: got %h want %h", obs, exp_v); end
    $display("tb: reset during MEM transaction");
  endtask

  initial begin
    n_cmp            = 0;
    n_err            = 0;
    rst_n            = 1'b0;
    bus.imem_rdata   = '0;
    bus.imem_ack     = 1'b0;
    bus.dmem_ack     = 1'b0;
    bus.branch_taken = 1'b0;
    bus.resume       = 1'b0;
    test_reset();
    test_rtype();
    test_load();
    test_store();
    test_branch();
    test_jump();
    test_special();
    test_imm();
    test_illegal();
    test_halt();
    test_ack_at_limit();
    test_timeout();
    test_reset_in_mem();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
